bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display block. It accepts an unsigned binary value on a start pulse, converts it with the shift-and-add-3 (double-dabble) algorithm at one bit per clock, and drives a packed, registered BCD word. That word connects straight to the display's `i_bcd_data` input. Values that do not fit in the available digits saturate to all nines and raise an overflow flag.

## Interface

Parameters:
- `DISPLAYS_NUM`, default 4: number of BCD digits produced. Legal range 1..8.
- `BIN_WIDTH`, default 14: width of the binary input. Legal range 1..27.

Ports:
- `i_clk`, input, 1: single clock. All logic is on its rising edge.
- `i_rst`, input, 1: synchronous, active-low reset. It is sampled on the `i_clk` rising edge, and 0 means reset.
- `i_start`, input, 1: conversion request. Sampled only in IDLE.
- `i_bin`, input, `BIN_WIDTH`: unsigned binary value. Captured on the edge that accepts `i_start`.
- `o_busy`, output, 1: high while a conversion is in progress.
- `o_done`, output, 1: one-cycle pulse indicating that `o_bcd_data` and `o_overflow` have just been updated.
- `o_overflow`, output, 1: set when the last captured value exceeded 10^`DISPLAYS_NUM` − 1.
- `o_bcd_data`, output, `DISPLAYS_NUM*4`: packed BCD result. Digit 0 (the units digit) is in bits [3:0], and digit k is in bits [4k+3:4k].

## Operation

- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - If `i_start` is 1, capture `i_bin` into the shift register, clear the BCD scratch digits, load the bit counter with `BIN_WIDTH`, and go to SHIFT.
  - Otherwise, stay in IDLE.
- **SHIFT:** each cycle performs one iteration:
  - every scratch digit ≥ 5 gets 3 added;
  - then the concatenation {scratch, shift register} shifts left by 1;
  - the counter decrements;
  - when the counter reaches 0, go to DONE.
- **DONE:**
  - If the captured value > MAX (localparam MAX = 10^`DISPLAYS_NUM` − 1), write all digits = 4'h9 to `o_bcd_data` and set `o_overflow` = 1.
  - Otherwise, write the scratch digits to `o_bcd_data` and set `o_overflow` = 0.
  - Assert `o_done` for this single update and return to IDLE.
- **Overflow compare:** performed against the captured copy of `i_bin`, which is held unchanged through SHIFT. The comparison is at least 32 bits wide.
- **Scratch width:** `DISPLAYS_NUM*4` bits. Any shift-out beyond the top digit is discarded; the overflow path covers that case.
- **Output hold:** `o_bcd_data` and `o_overflow` change only in DONE. They hold their values across IDLE and SHIFT, so the display never sees intermediate values.
- **`i_start` outside IDLE:** ignored. It is not queued.
- **`i_bin` outside the capture edge:** don't-care.

## Timing

- **Reset values** (any cycle where `i_rst` = 0 at the edge):
  - state = IDLE;
  - `o_busy` = 0, `o_done` = 0, `o_overflow` = 0;
  - `o_bcd_data` = 0;
  - scratch, shift register and counter = 0.
- **Reset mid-conversion:** aborts the conversion. No `o_done` pulse is produced, and the outputs go to their reset values.
- **Latency:** take `i_start` accepted at edge E.
  - SHIFT occupies edges E+1 through E+`BIN_WIDTH`.
  - DONE occupies edge E+`BIN_WIDTH`+1.
  - `o_done` = 1, together with new `o_bcd_data` and `o_overflow`, is visible for exactly one cycle after edge E+`BIN_WIDTH`+1.
  - Total: `BIN_WIDTH`+2 edges from the accepting edge until `o_done` is visible.
- **`o_busy`:**
  - goes to 1 after edge E;
  - goes to 0 after edge E+`BIN_WIDTH`+1, i.e. it is 0 in the same cycle that `o_done` is 1.
- **Back-to-back conversions:** `i_start` held high during the `o_done` cycle is accepted at the next edge. The minimum spacing between accepted starts is `BIN_WIDTH`+2 edges.
- **Output registering:** all outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- **Reset:** assert `i_rst` = 0 for 3 cycles with `i_start` = 1 → `o_bcd_data` = 0, `o_busy` = 0, `o_done` = 0, `o_overflow` = 0 throughout.
- **Nominal conversion:** defaults; `i_bin` = 1234 with a one-cycle `i_start` → `o_busy` high for 15 cycles, then `o_done` for 1 cycle with `o_bcd_data` = 16'h1234 and `o_overflow` = 0; the value is held afterwards.
- **Boundary values:**
  - `i_bin` = 0 → 16'h0000;
  - `i_bin` = 9999 → 16'h9999 with `o_overflow` = 0;
  - `i_bin` = 10000 → 16'h9999 with `o_overflow` = 1;
  - `i_bin` = 16383 → 16'h9999 with `o_overflow` = 1.
- **Start while busy:** start a conversion of 42; pulse `i_start` with `i_bin` = 7777 at cycle 5 → only 16'h0042 is produced, and exactly one `o_done` pulse occurs.
- **Reset mid-conversion:** reset at cycle 8 of a conversion of 5678 → no `o_done`, `o_bcd_data` = 0; a following conversion of 5678 → 16'h5678.
- **Back-to-back:** hold `i_start` = 1 continuously, changing `i_bin` 1, 2, 3 on each accept edge → `o_done` pulses every 16 cycles with 16'h0001, 16'h0002, 16'h0003.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary producer and bin2bcd_seq.
// The producer drives start/bin and the converter returns busy/done/overflow and the BCD word.
interface bin2bcd_seq_if #(
  parameter int DISPLAYS_NUM = 4,
  parameter int BIN_WIDTH    = 14
);
  logic                      i_start;
  logic [BIN_WIDTH-1:0]      i_bin;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_overflow;
  logic [DISPLAYS_NUM*4-1:0] o_bcd_data;

  modport master (
    output i_start, i_bin,
    input  o_busy, o_done, o_overflow, o_bcd_data
  );

  modport slave (
    input  i_start, i_bin,
    output o_busy, o_done, o_overflow, o_bcd_data
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, saturating to all nines.
// Latency BIN_WIDTH+2 edges from accepted start to o_done; starts are ignored while busy, never queued.
module bin2bcd_seq #(
  parameter int DISPLAYS_NUM = 4,
  parameter int BIN_WIDTH    = 14
) (
  input logic         i_clk,
  input logic         i_rst,
  bin2bcd_seq_if.slave bus
);
  localparam int DW = DISPLAYS_NUM * 4;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX = pow10(DISPLAYS_NUM) - 64'd1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BIN_WIDTH-1:0] sh_q, sh_d;
  logic [DW-1:0]        scr_q, scr_d, scr_adj;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    for (int k = 0; k < DISPLAYS_NUM; k++) begin
      scr_adj[4*k +: 4] = (scr_q[4*k +: 4] >= 4'd5) ? scr_q[4*k +: 4] + 4'd3 : scr_q[4*k +: 4];
    end

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          bin_d   = bus.i_bin;
          sh_d    = bus.i_bin;
          scr_d   = '0;
          cnt_d   = CW'(BIN_WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Bits shifted out of the top digit are dropped; the overflow compare covers them.
        scr_d = {scr_adj[DW-2:0], sh_q[BIN_WIDTH-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (64'(bin_q) > MAX) begin
          bcd_d = {DISPLAYS_NUM{4'h9}};
          ovf_d = 1'b1;
        end else begin
          bcd_d = scr_q;
          ovf_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_bcd_data = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq with hand-computed BCD results and cycle-exact handshake checks.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_bin2bcd_seq;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   pulses;
  int   gap;
  logic [15:0] seen_bcd;
  logic        got;

  bin2bcd_seq_if #(.DISPLAYS_NUM(4), .BIN_WIDTH(14)) bus ();

  bin2bcd_seq #(.DISPLAYS_NUM(4), .BIN_WIDTH(14)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input logic [13:0] v, input logic [15:0] eb, input logic eo, input string tag);
    int  busy_cyc;
    bit  seen;
    busy_cyc = 0;
    seen     = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_bin   = v;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_bin   = 14'($urandom);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.o_done) seen = 1'b1;
      else begin
        if (bus.o_busy) busy_cyc++;
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd15);
    chk({tag, "_bcd"}, 64'(bus.o_bcd_data), 64'(eb));
    chk({tag, "_ovf"}, 64'(bus.o_overflow), 64'(eo));
    chk({tag, "_busy_at_done"}, 64'(bus.o_busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done_single"}, 64'(bus.o_done), 64'd0);
    chk({tag, "_bcd_held"}, 64'(bus.o_bcd_data), 64'(eb));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst         = 1'b0;
    bus.i_start = 1'b1;
    bus.i_bin   = 14'd1234;

    // Reset held low with start asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_bcd", 64'(bus.o_bcd_data), 64'd0);
      chk("rst_busy", 64'(bus.o_busy), 64'd0);
      chk("rst_done", 64'(bus.o_done), 64'd0);
      chk("rst_ovf", 64'(bus.o_overflow), 64'd0);
    end
    rst         = 1'b1;
    bus.i_start = 1'b0;

    convert(14'd1234,  16'h1234, 1'b0, "nominal");
    convert(14'd0,     16'h0000, 1'b0, "zero");
    convert(14'd9999,  16'h9999, 1'b0, "max");
    convert(14'd10000, 16'h9999, 1'b1, "ovf_10000");
    convert(14'd16383, 16'h9999, 1'b1, "ovf_16383");
    convert(14'd5,     16'h0005, 1'b0, "after_ovf");

    // Start while busy: the second request must be ignored.
    pulses   = 0;
    seen_bcd = '0;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_bin   = 14'd42;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_bin   = 14'd7777;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_done) begin
        pulses++;
        seen_bcd = bus.o_bcd_data;
      end
      @(negedge clk);
    end
    chk("busy_start_pulses", 64'(pulses), 64'd1);
    chk("busy_start_bcd", 64'(seen_bcd), 64'h0042);
    chk("busy_start_hold", 64'(bus.o_bcd_data), 64'h0042);

    // Reset in the middle of a conversion.
    bus.i_start = 1'b1;
    bus.i_bin   = 14'd5678;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_bcd", 64'(bus.o_bcd_data), 64'd0);
    chk("midrst_busy", 64'(bus.o_busy), 64'd0);
    rst    = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.o_done) pulses++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(pulses), 64'd0);
    chk("midrst_bcd_after", 64'(bus.o_bcd_data), 64'd0);
    convert(14'd5678, 16'h5678, 1'b0, "post_rst");

    // Back-to-back with start held high.
    bus.i_start = 1'b1;
    bus.i_bin   = 14'd1;
    for (int r = 1; r <= 3; r++) begin
      got = 1'b0;
      gap = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        gap++;
        if (bus.o_done) got = 1'b1;
      end
      chk($sformatf("b2b%0d_done_seen", r), 64'(got), 64'd1);
      chk($sformatf("b2b%0d_spacing", r), 64'(gap), 64'd16);
      chk($sformatf("b2b%0d_bcd", r), 64'(bus.o_bcd_data), 64'(r));
      if (r == 3) bus.i_start = 1'b0;
      else        bus.i_bin   = 14'(r + 1);
    end
    @(negedge clk);
    chk("b2b_stop_busy", 64'(bus.o_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
